// File: rtl/id_stage_bypass_if.sv
// id_stage_bypass_if: IF offer, EX handshake, bypass network and regfile port of the decode stage
interface id_stage_bypass_if #(
  parameter int NUM_FWD     = 3,
  parameter int STALL_CNT_W = 32
);
  logic                   es_allowin;
  logic                   ds_allowin;
  logic                   fs_to_ds_valid;
  logic [31:0]            fs_inst;
  logic [31:0]            fs_pc;
  logic [NUM_FWD-1:0]     fwd_valid;
  logic [NUM_FWD-1:0]     fwd_we;
  logic [NUM_FWD-1:0]     fwd_ready;
  logic [5*NUM_FWD-1:0]   fwd_dest;
  logic [32*NUM_FWD-1:0]  fwd_data;
  logic [4:0]             rf_raddr1;
  logic [4:0]             rf_raddr2;
  logic [31:0]            rf_rdata1;
  logic [31:0]            rf_rdata2;
  logic                   ds_to_es_valid;
  logic [31:0]            ds_inst;
  logic [31:0]            ds_pc;
  logic [31:0]            rj_value;
  logic [31:0]            rkd_value;
  logic                   br_taken;
  logic [31:0]            br_target;
  logic [STALL_CNT_W-1:0] stall_cnt;
  modport slave (
    input  es_allowin, fs_to_ds_valid, fs_inst, fs_pc,
    input  fwd_valid, fwd_we, fwd_ready, fwd_dest, fwd_data, rf_rdata1, rf_rdata2,
    output ds_allowin, rf_raddr1, rf_raddr2, ds_to_es_valid, ds_inst, ds_pc,
    output rj_value, rkd_value, br_taken, br_target, stall_cnt
  );
  modport master (
    output es_allowin, fs_to_ds_valid, fs_inst, fs_pc,
    output fwd_valid, fwd_we, fwd_ready, fwd_dest, fwd_data, rf_rdata1, rf_rdata2,
    input  ds_allowin, rf_raddr1, rf_raddr2, ds_to_es_valid, ds_inst, ds_pc,
    input  rj_value, rkd_value, br_taken, br_target, stall_cnt
  );
endinterface

// File: rtl/id_stage_bypass.sv
// id_stage_bypass: decode stage with operand bypass, load-use interlock and branch resolution
module id_stage_bypass #(
  parameter int NUM_FWD     = 3,
  parameter int STALL_CNT_W = 32
) (
  input logic              clk,
  input logic              reset,
  id_stage_bypass_if.slave bus
);
  logic                   r_valid;
  logic [31:0]            r_inst;
  logic [31:0]            r_pc;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   w_alu_rr, w_alu_imm, w_st_w, w_jirl, w_b, w_bl, w_beq, w_bne;
  logic                   w_use1, w_use2;
  logic [4:0]             w_src1, w_src2;
  logic [31:0]            w_val1, w_val2;
  logic                   w_rdy1, w_rdy2;
  logic                   w_ready_go, w_cond, w_br_taken, w_allowin;
  logic [31:0]            w_offs;
  assign w_alu_rr  = r_inst[31:15] inside {17'h00020, 17'h00022, 17'h00024, 17'h00025,
                                           17'h00028, 17'h00029, 17'h0002a, 17'h0002b};
  assign w_alu_imm = (r_inst[31:15] inside {17'h00081, 17'h00089, 17'h00091}) ||
                     (r_inst[31:22] inside {10'h00a, 10'h0a2});
  assign w_st_w    = r_inst[31:22] == 10'h0a6;
  assign w_jirl    = r_inst[31:26] == 6'h13;
  assign w_b       = r_inst[31:26] == 6'h14;
  assign w_bl      = r_inst[31:26] == 6'h15;
  assign w_beq     = r_inst[31:26] == 6'h16;
  assign w_bne     = r_inst[31:26] == 6'h17;
  assign w_use1    = w_alu_rr | w_alu_imm | w_st_w | w_jirl | w_beq | w_bne;
  assign w_use2    = w_alu_rr | w_st_w | w_beq | w_bne;
  assign w_src1    = r_inst[9:5];
  assign w_src2    = (w_beq | w_bne | w_st_w) ? r_inst[4:0] : r_inst[14:10];
  // walk from oldest to youngest so the youngest match overrides, carrying its ready bit
  always_comb begin
    w_val1 = bus.rf_rdata1;
    w_val2 = bus.rf_rdata2;
    w_rdy1 = 1'b1;
    w_rdy2 = 1'b1;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (w_use1 && w_src1 != 5'd0 && bus.fwd_valid[i] && bus.fwd_we[i] && bus.fwd_dest[5*i +: 5] == w_src1) begin
        w_val1 = bus.fwd_data[32*i +: 32];
        w_rdy1 = bus.fwd_ready[i];
      end
      if (w_use2 && w_src2 != 5'd0 && bus.fwd_valid[i] && bus.fwd_we[i] && bus.fwd_dest[5*i +: 5] == w_src2) begin
        w_val2 = bus.fwd_data[32*i +: 32];
        w_rdy2 = bus.fwd_ready[i];
      end
    end
  end
  assign w_ready_go = w_rdy1 & w_rdy2;
  assign w_cond     = (w_beq & (w_val1 == w_val2)) | (w_bne & (w_val1 != w_val2)) | w_b | w_bl | w_jirl;
  assign w_br_taken = r_valid & w_ready_go & bus.es_allowin & w_cond & ~reset;
  assign w_allowin  = ~r_valid | (w_ready_go & bus.es_allowin);
  assign w_offs     = (w_b | w_bl) ? {{4{r_inst[9]}}, r_inst[9:0], r_inst[25:10], 2'b00}
                                   : {{14{r_inst[25]}}, r_inst[25:10], 2'b00};
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_inst      <= '0;
      r_pc        <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_allowin) r_valid <= bus.fs_to_ds_valid & ~w_br_taken;
      if (w_allowin && bus.fs_to_ds_valid) begin
        r_inst <= bus.fs_inst;
        r_pc   <= bus.fs_pc;
      end
      if (r_valid && !w_ready_go && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end
  assign bus.ds_allowin     = w_allowin;
  assign bus.rf_raddr1      = w_src1;
  assign bus.rf_raddr2      = w_src2;
  assign bus.ds_to_es_valid = r_valid & w_ready_go;
  assign bus.ds_inst        = r_inst;
  assign bus.ds_pc          = r_pc;
  assign bus.rj_value       = w_val1;
  assign bus.rkd_value      = w_val2;
  assign bus.br_taken       = w_br_taken;
  assign bus.br_target      = (w_jirl ? w_val1 : r_pc) + w_offs;
  assign bus.stall_cnt      = r_stall_cnt;
endmodule

// File: tb/tb_id_stage_bypass.sv
// tb_id_stage_bypass: vector table, hand-written corner sequences and a randomized run against a reference model
module tb_id_stage_bypass;
  localparam int N = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  id_stage_bypass_if #(.NUM_FWD(N), .STALL_CNT_W(32)) bus ();
  id_stage_bypass_if #(.NUM_FWD(N), .STALL_CNT_W(2))  bus2 ();
  id_stage_bypass #(.NUM_FWD(N), .STALL_CNT_W(32)) dut  (.clk(clk), .reset(reset), .bus(bus));
  id_stage_bypass #(.NUM_FWD(N), .STALL_CNT_W(2))  dut2 (.clk(clk), .reset(reset), .bus(bus2));
  function automatic logic [31:0] rf(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : 32'h1000 + 32'(a);
  endfunction
  assign bus.rf_rdata1       = rf(bus.rf_raddr1);
  assign bus.rf_rdata2       = rf(bus.rf_raddr2);
  assign bus2.rf_rdata1      = rf(bus2.rf_raddr1);
  assign bus2.rf_rdata2      = rf(bus2.rf_raddr2);
  assign bus2.es_allowin     = bus.es_allowin;
  assign bus2.fs_to_ds_valid = bus.fs_to_ds_valid;
  assign bus2.fs_inst        = bus.fs_inst;
  assign bus2.fs_pc          = bus.fs_pc;
  assign bus2.fwd_valid      = bus.fwd_valid;
  assign bus2.fwd_we         = bus.fwd_we;
  assign bus2.fwd_ready      = bus.fwd_ready;
  assign bus2.fwd_dest       = bus.fwd_dest;
  assign bus2.fwd_data       = bus.fwd_data;
  int checks = 0;
  int errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] add_w(input logic [4:0] d, j, k);
    return {17'h00020, k, j, d};
  endfunction
  function automatic logic [31:0] beq(input logic [4:0] j, d, input logic [15:0] o);
    return {6'h16, o, j, d};
  endfunction
  function automatic logic [31:0] bne(input logic [4:0] j, d, input logic [15:0] o);
    return {6'h17, o, j, d};
  endfunction
  function automatic logic [31:0] jirl(input logic [4:0] d, j, input logic [15:0] o);
    return {6'h13, o, j, d};
  endfunction
  function automatic logic [31:0] br26(input logic link, input logic [25:0] o);
    return {link ? 6'h15 : 6'h14, o[15:0], o[25:16]};
  endfunction
  function automatic logic [31:0] lu12i(input logic [4:0] d, input logic [19:0] si);
    return {7'h0a, si, d};
  endfunction
  function automatic logic [31:0] st_w(input logic [4:0] d, j, input logic [11:0] si);
    return {10'h0a6, si, j, d};
  endfunction
  // instruction class: 0 other, 1 reg-reg alu, 2 imm alu/ld, 3 st.w, 4 beq, 5 bne, 6 jirl, 7 b/bl, 8 lu12i.w
  function automatic int kind(input logic [31:0] in);
    if (in[31:15] inside {17'h20, 17'h22, 17'h24, 17'h25, 17'h28, 17'h29, 17'h2a, 17'h2b}) return 1;
    if ((in[31:15] inside {17'h81, 17'h89, 17'h91}) || (in[31:22] inside {10'h00a, 10'h0a2})) return 2;
    if (in[31:22] == 10'h0a6) return 3;
    if (in[31:26] == 6'h13) return 6;
    if (in[31:26] == 6'h14 || in[31:26] == 6'h15) return 7;
    if (in[31:26] == 6'h16) return 4;
    if (in[31:26] == 6'h17) return 5;
    if (in[31:25] == 7'h0a) return 8;
    return 0;
  endfunction
  logic        m_valid = 1'b0;
  logic [31:0] m_inst = '0, m_pc = '0, m_cnt = '0;
  int          m_cnt2 = 0;
  logic [4:0]  e_a1, e_a2;
  logic [31:0] e_rj, e_rkd, e_tgt;
  logic        e_go, e_tov, e_allow, e_bt;
  bit          mon = 1'b0;
  task automatic fwd_look(input logic [4:0] s, output logic [31:0] v, output logic rdy);
    v = rf(s);
    rdy = 1'b1;
    if (s == 5'd0) return;
    for (int i = 0; i < N; i++)
      if (bus.fwd_valid[i] && bus.fwd_we[i] && bus.fwd_dest[5*i +: 5] == s) begin
        v = bus.fwd_data[32*i +: 32];
        rdy = bus.fwd_ready[i];
        return;
      end
  endtask
  task automatic model_eval;
    int k, o;
    logic r1, r2, cond;
    logic [31:0] v;
    k = kind(m_inst);
    e_a1 = m_inst[9:5];
    e_a2 = (k inside {3, 4, 5}) ? m_inst[4:0] : m_inst[14:10];
    e_rj = rf(e_a1);
    e_rkd = rf(e_a2);
    r1 = 1'b1;
    r2 = 1'b1;
    if (k inside {1, 2, 3, 4, 5, 6}) fwd_look(e_a1, e_rj, r1);
    if (k inside {1, 3, 4, 5}) fwd_look(e_a2, e_rkd, r2);
    e_go = r1 && r2;
    cond = (k == 4 && e_rj == e_rkd) || (k == 5 && e_rj != e_rkd) || k == 6 || k == 7;
    e_tov = m_valid && e_go;
    e_allow = !m_valid || (e_go && bus.es_allowin);
    e_bt = e_tov && bus.es_allowin && cond && !reset;
    if (k == 7) o = $signed({m_inst[9:0], m_inst[25:10]});
    else o = $signed(m_inst[25:10]);
    v = (k == 6) ? e_rj : m_pc;
    e_tgt = v + 32'(o * 4);
  endtask
  always @(negedge clk) if (mon) begin
    model_eval;
    chk1("ds_allowin", bus.ds_allowin, e_allow);
    chk1("ds_to_es_valid", bus.ds_to_es_valid, e_tov);
    chk1("br_taken", bus.br_taken, e_bt);
    chk("ds_inst", bus.ds_inst, m_inst);
    chk("ds_pc", bus.ds_pc, m_pc);
    chk("rf_raddr1", 32'(bus.rf_raddr1), 32'(e_a1));
    chk("rf_raddr2", 32'(bus.rf_raddr2), 32'(e_a2));
    chk("stall_cnt", bus.stall_cnt, m_cnt);
    chk("stall_cnt_w2", 32'(bus2.stall_cnt), 32'(m_cnt2));
    if (m_valid) begin
      chk("rj_value", bus.rj_value, e_rj);
      chk("rkd_value", bus.rkd_value, e_rkd);
    end
    if (e_bt) chk("br_target", bus.br_target, e_tgt);
  end
  always @(posedge clk) begin
    model_eval;
    if (reset) begin
      m_valid = 1'b0;
      m_inst = '0;
      m_pc = '0;
      m_cnt = '0;
      m_cnt2 = 0;
    end else begin
      if (m_valid && !e_go) begin
        if (m_cnt != 32'hffff_ffff) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (e_allow) begin
        if (bus.fs_to_ds_valid) begin
          m_inst = bus.fs_inst;
          m_pc = bus.fs_pc;
        end
        m_valid = bus.fs_to_ds_valid && !e_bt;
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    bus.fs_to_ds_valid = 1'b0;
    bus.fwd_valid = '0;
    bus.fwd_we = '0;
    bus.fwd_ready = '1;
    bus.fwd_dest = '0;
    bus.fwd_data = '0;
    bus.es_allowin = 1'b1;
  endtask
  task automatic drain;
    idle;
    repeat (2) tick;
  endtask
  task automatic load(input logic [31:0] in, input logic [31:0] pc);
    bus.fs_to_ds_valid = 1'b1;
    bus.fs_inst = in;
    bus.fs_pc = pc;
    tick;
    bus.fs_to_ds_valid = 1'b0;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    repeat (2) tick;
    reset = 1'b0;
  endtask
  task automatic set_fwd(input logic [2:0] v, w, r, input logic [14:0] d, input logic [95:0] dat);
    bus.fwd_valid = v;
    bus.fwd_we = w;
    bus.fwd_ready = r;
    bus.fwd_dest = d;
    bus.fwd_data = dat;
  endtask
  function automatic logic [31:0] rand_inst();
    logic [4:0] a = 5'($urandom_range(0, 7));
    logic [4:0] k = 5'($urandom_range(0, 7));
    logic [4:0] d = 5'($urandom_range(0, 7));
    logic [15:0] o = 16'($urandom_range(0, 15)) - 16'd8;
    case ($urandom_range(0, 11))
      0: return add_w(d, a, k);
      1: return {17'h0002b, k, a, d};
      2: return {10'h00a, 12'($urandom), a, d};
      3: return {17'h00081, k, a, d};
      4: return st_w(d, a, 12'h4);
      5: return beq(a, d, o);
      6: return bne(a, d, o);
      7: return jirl(d, a, o);
      8: return br26(1'($urandom), 26'($urandom));
      9: return lu12i(d, 20'($urandom));
      10: return {10'h0a2, 12'h8, a, d};
      default: return $urandom;
    endcase
  endfunction
  typedef struct {
    logic [31:0] inst, pc;
    logic [2:0]  fv, fw, fr;
    logic [14:0] fd;
    logic [95:0] fdat;
    logic [31:0] rj, rkd;
    logic        go, bt;
    logic [31:0] tgt;
  } vec_t;
  vec_t vt [17];
  initial begin
    vt[0]  = '{add_w(5'd3, 5'd5, 5'd6), 32'h0, 3'b011, 3'b011, 3'b111, {5'd0, 5'd5, 5'd5}, {32'h0, 32'h22, 32'h11}, 32'h11, 32'h1006, 1'b1, 1'b0, 32'h0};
    vt[1]  = '{add_w(5'd1, 5'd0, 5'd0), 32'h0, 3'b111, 3'b111, 3'b000, 15'd0, {32'h33, 32'h44, 32'h55}, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0};
    vt[2]  = '{add_w(5'd1, 5'd7, 5'd2), 32'h0, 3'b011, 3'b011, 3'b110, {5'd0, 5'd7, 5'd7}, {32'h0, 32'h66, 32'h33}, 32'h33, 32'h1002, 1'b0, 1'b0, 32'h0};
    vt[3]  = '{add_w(5'd1, 5'd7, 5'd2), 32'h0, 3'b011, 3'b011, 3'b101, {5'd0, 5'd7, 5'd7}, {32'h0, 32'h66, 32'h33}, 32'h33, 32'h1002, 1'b1, 1'b0, 32'h0};
    vt[4]  = '{add_w(5'd1, 5'd7, 5'd2), 32'h0, 3'b001, 3'b000, 3'b000, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'h33}, 32'h1007, 32'h1002, 1'b1, 1'b0, 32'h0};
    vt[5]  = '{add_w(5'd1, 5'd7, 5'd2), 32'h0, 3'b000, 3'b111, 3'b000, {5'd7, 5'd7, 5'd7}, {32'h1, 32'h2, 32'h3}, 32'h1007, 32'h1002, 1'b1, 1'b0, 32'h0};
    vt[6]  = '{add_w(5'd1, 5'd2, 5'd9), 32'h0, 3'b100, 3'b100, 3'b000, {5'd9, 5'd0, 5'd0}, {32'h77, 32'h0, 32'h0}, 32'h1002, 32'h77, 1'b0, 1'b0, 32'h0};
    vt[7]  = '{beq(5'd1, 5'd2, 16'h4), 32'h1c000000, 3'b001, 3'b001, 3'b111, {5'd0, 5'd0, 5'd2}, {32'h0, 32'h0, 32'h1001}, 32'h1001, 32'h1001, 1'b1, 1'b1, 32'h1c000010};
    vt[8]  = '{bne(5'd1, 5'd2, 16'h4), 32'h1c000000, 3'b001, 3'b001, 3'b111, {5'd0, 5'd0, 5'd2}, {32'h0, 32'h0, 32'h1001}, 32'h1001, 32'h1001, 1'b1, 1'b0, 32'h0};
    vt[9]  = '{bne(5'd1, 5'd2, 16'hfffe), 32'h1c000100, 3'b000, 3'b000, 3'b111, 15'd0, 96'h0, 32'h1001, 32'h1002, 1'b1, 1'b1, 32'h1c0000f8};
    vt[10] = '{br26(1'b0, 26'h3ffffff), 32'h1c000000, 3'b001, 3'b001, 3'b000, {5'd0, 5'd0, 5'd31}, 96'h5, 32'h101f, 32'h101f, 1'b1, 1'b1, 32'h1bfffffc};
    vt[11] = '{br26(1'b1, 26'h0000100), 32'h1c000000, 3'b000, 3'b000, 3'b111, 15'd0, 96'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h1c000400};
    vt[12] = '{jirl(5'd1, 5'd4, 16'h8), 32'h0, 3'b010, 3'b010, 3'b111, {5'd0, 5'd4, 5'd0}, {32'h0, 32'h1000, 32'h0}, 32'h1000, 32'h1008, 1'b1, 1'b1, 32'h1020};
    vt[13] = '{lu12i(5'd5, 20'h00007), 32'h0, 3'b001, 3'b001, 3'b000, {5'd0, 5'd0, 5'd7}, 96'h9, 32'h1007, 32'h0, 1'b1, 1'b0, 32'h0};
    vt[14] = '{st_w(5'd8, 5'd2, 12'h010), 32'h0, 3'b001, 3'b001, 3'b000, {5'd0, 5'd0, 5'd8}, {32'h0, 32'h0, 32'h88}, 32'h1002, 32'h88, 1'b0, 1'b0, 32'h0};
    vt[15] = '{beq(5'd0, 5'd0, 16'h8), 32'hfffffff0, 3'b000, 3'b000, 3'b111, 15'd0, 96'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h00000010};
    vt[16] = '{32'hffffffff, 32'h0, 3'b001, 3'b001, 3'b000, {5'd0, 5'd0, 5'd31}, 96'h1, 32'h101f, 32'h101f, 1'b1, 1'b0, 32'h0};
    idle;
    bus.fs_inst = '0;
    bus.fs_pc = '0;
    do_reset;
    mon = 1'b1;
    @(negedge clk);
    chk1("reset ds_to_es_valid", bus.ds_to_es_valid, 1'b0);
    chk1("reset br_taken", bus.br_taken, 1'b0);
    chk1("reset ds_allowin", bus.ds_allowin, 1'b1);
    chk("reset ds_inst", bus.ds_inst, 32'h0);
    chk("reset ds_pc", bus.ds_pc, 32'h0);
    chk("reset stall_cnt", bus.stall_cnt, 32'h0);
    for (int t = 0; t < 17; t++) begin
      drain;
      load(vt[t].inst, vt[t].pc);
      set_fwd(vt[t].fv, vt[t].fw, vt[t].fr, vt[t].fd, vt[t].fdat);
      @(negedge clk);
      chk($sformatf("vec%0d rj_value", t), bus.rj_value, vt[t].rj);
      chk($sformatf("vec%0d rkd_value", t), bus.rkd_value, vt[t].rkd);
      chk1($sformatf("vec%0d ready_go", t), bus.ds_to_es_valid, vt[t].go);
      chk1($sformatf("vec%0d br_taken", t), bus.br_taken, vt[t].bt);
      if (vt[t].bt) chk($sformatf("vec%0d br_target", t), bus.br_target, vt[t].tgt);
    end
    drain;
    do_reset;
    load(add_w(5'd1, 5'd7, 5'd0), 32'h100);
    set_fwd(3'b001, 3'b001, 3'b000, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'hcafe});
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk1("interlock allowin", bus.ds_allowin, 1'b0);
      chk1("interlock to_es", bus.ds_to_es_valid, 1'b0);
      tick;
      chk("interlock count", bus.stall_cnt, 32'(k));
    end
    bus.fwd_ready = 3'b111;
    @(negedge clk);
    chk1("release to_es", bus.ds_to_es_valid, 1'b1);
    chk("release rj", bus.rj_value, 32'hcafe);
    tick;
    chk("release count frozen", bus.stall_cnt, 32'd3);
    drain;
    load(beq(5'd1, 5'd2, 16'h4), 32'h1c000000);
    set_fwd(3'b001, 3'b001, 3'b111, {5'd0, 5'd0, 5'd2}, {32'h0, 32'h0, 32'h1001});
    bus.fs_to_ds_valid = 1'b1;
    bus.fs_inst = add_w(5'd3, 5'd4, 5'd5);
    bus.fs_pc = 32'h1c000004;
    @(negedge clk);
    chk1("squash br_taken", bus.br_taken, 1'b1);
    chk("squash br_target", bus.br_target, 32'h1c000010);
    tick;
    bus.fs_to_ds_valid = 1'b0;
    @(negedge clk);
    chk1("squash next to_es", bus.ds_to_es_valid, 1'b0);
    chk1("squash one pulse", bus.br_taken, 1'b0);
    drain;
    load(br26(1'b0, 26'h10), 32'h1c000000);
    bus.es_allowin = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("held branch br_taken", bus.br_taken, 1'b0);
      tick;
    end
    bus.es_allowin = 1'b1;
    @(negedge clk);
    chk1("released branch br_taken", bus.br_taken, 1'b1);
    chk("released branch target", bus.br_target, 32'h1c000040);
    tick;
    @(negedge clk);
    chk1("released branch once", bus.br_taken, 1'b0);
    drain;
    do_reset;
    load(add_w(5'd1, 5'd7, 5'd0), 32'h200);
    set_fwd(3'b001, 3'b001, 3'b000, {5'd0, 5'd0, 5'd7}, 96'h0);
    for (int k = 1; k <= 6; k++) begin
      tick;
      chk("sat count w2", 32'(bus2.stall_cnt), (k < 3) ? 32'(k) : 32'd3);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    @(negedge clk);
    chk("sat reset count", 32'(bus2.stall_cnt), 32'd0);
    chk1("sat reset to_es", bus2.ds_to_es_valid, 1'b0);
    chk1("sat reset allowin", bus2.ds_allowin, 1'b1);
    drain;
    bus.es_allowin = 1'b0;
    load(br26(1'b0, 26'h20), 32'h300);
    reset = 1'b1;
    bus.es_allowin = 1'b1;
    @(negedge clk);
    chk1("reset mid-branch no pulse", bus.br_taken, 1'b0);
    tick;
    reset = 1'b0;
    @(negedge clk);
    chk1("reset mid-branch discarded", bus.ds_to_es_valid, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      bus.fs_to_ds_valid = $urandom_range(0, 3) != 0;
      bus.fs_inst = rand_inst();
      bus.fs_pc = $urandom;
      bus.es_allowin = $urandom_range(0, 3) != 0;
      bus.fwd_valid = 3'($urandom);
      bus.fwd_we = 3'($urandom);
      bus.fwd_ready = ~(3'($urandom) & 3'($urandom));
      for (int i = 0; i < N; i++) begin
        bus.fwd_dest[5*i +: 5] = 5'($urandom_range(0, 7));
        bus.fwd_data[32*i +: 32] = ($urandom_range(0, 2) == 0) ? rf(5'($urandom_range(0, 7))) : $urandom;
      end
      reset = $urandom_range(0, 99) == 0;
      tick;
    end
    reset = 1'b0;
    drain;
    mon = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
